// File: rtl/mem_dma_engine_if.sv
// rtl/mem_dma_engine_if.sv - memory-port bundle between the DMA engine (master) and the ideal memory (slave)
interface mem_dma_engine_if #(
    parameter int AW = 8
);
    logic [AW-1:0] Raddr1;
    logic [AW-1:0] Raddr2;
    logic          Rden1;
    logic          Rden2;
    logic [31:0]   Rdata1;
    logic [31:0]   Rdata2;
    logic [AW-1:0] Waddr;
    logic          Wren;
    logic [31:0]   Wdata;

    modport master (
        output Raddr1, Raddr2, Rden1, Rden2, Waddr, Wren, Wdata,
        input  Rdata1, Rdata2
    );

    modport slave (
        input  Raddr1, Raddr2, Rden1, Rden2, Waddr, Wren, Wdata,
        output Rdata1, Rdata2
    );
endinterface

// File: rtl/mem_dma_engine.sv
// rtl/mem_dma_engine.sv - word block-copy engine with optional read-back verify (MEM_DMA_VERIFY_EN)
module mem_dma_engine #(
    parameter  int ADDR_WIDTH = 10,
    localparam int AW         = ADDR_WIDTH - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_off,
    mem_dma_engine_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE  = 3'd2,
`ifdef MEM_DMA_VERIFY_EN
        S_VERIFY = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW:0]   len_r;
    logic [AW-1:0] off;
    logic [31:0]   data_buf;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          last_word;
    logic          mismatch;

    // Address sums wrap modulo 2^AW by truncation to AW bits.
    assign src_addr  = src_r + off;
    assign dst_addr  = dst_r + off;
    assign last_word = ((AW+1)'(off) + (AW+1)'(1)) == len_r;

`ifdef MEM_DMA_VERIFY_EN
    assign mismatch = mem.Rdata1 != mem.Rdata2;
`else
    logic unused_rdata2;
    assign mismatch      = 1'b0;
    assign unused_rdata2 = ^mem.Rdata2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  state_nx = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef MEM_DMA_VERIFY_EN
                    state_nx = S_VERIFY;
`else
                    state_nx = S_DONE;
`endif
                end else begin
                    state_nx = S_READ;
                end
            end
`ifdef MEM_DMA_VERIFY_EN
            S_VERIFY: begin
                if (mismatch || last_word) begin
                    state_nx = S_DONE;
                end
            end
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The offset counter is reused by the verify walk, so it restarts at 0 after the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            off      <= '0;
            data_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r <= src_base;
                        dst_r <= dst_base;
                        len_r <= len;
                        off   <= '0;
                    end
                end
                S_READ:  data_buf <= mem.Rdata1;
                S_WRITE: off <= last_word ? '0 : off + 1'b1;
`ifdef MEM_DMA_VERIFY_EN
                S_VERIFY: begin
                    if (!mismatch && !last_word) begin
                        off <= off + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MEM_DMA_VERIFY_EN
    logic          err_r;
    logic [AW-1:0] err_off_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r     <= 1'b0;
            err_off_r <= '0;
        end else if (state == S_IDLE && start) begin
            err_r     <= 1'b0;
            err_off_r <= '0;
        end else if (state == S_VERIFY && mismatch) begin
            err_r     <= 1'b1;
            err_off_r <= off;
        end
    end

    assign err        = err_r;
    assign err_off    = err_off_r;
    assign mem.Rden2  = (state == S_VERIFY);
    assign mem.Rden1  = (state == S_READ) || (state == S_VERIFY);
    assign mem.Raddr2 = mem.Rden2 ? dst_addr : '0;
    assign busy       = (state == S_READ) || (state == S_WRITE) || (state == S_VERIFY);
`else
    assign err        = 1'b0;
    assign err_off    = '0;
    assign mem.Rden2  = 1'b0;
    assign mem.Rden1  = (state == S_READ);
    assign mem.Raddr2 = '0;
    assign busy       = (state == S_READ) || (state == S_WRITE);
`endif

    assign done       = (state == S_DONE);
    assign mem.Raddr1 = mem.Rden1 ? src_addr : '0;
    assign mem.Wren   = (state == S_WRITE);
    assign mem.Waddr  = mem.Wren ? dst_addr : '0;
    assign mem.Wdata  = mem.Wren ? data_buf : '0;

endmodule

// File: doc/mem_dma_engine.md
# mem_dma_engine

Word-granular block-copy initiator that drives the ideal memory's write port and two read ports, moving `len` 32-bit words from a source window to a destination window without CPU involvement. It sits beside the multi-cycle CPU core on the same memory ports, muxed in by the top level while `busy` is high. It is used for simulation preloading and region copies, with an optional read-back verify pass.

## Interface
Parameters:
- `ADDR_WIDTH`, 10. Memory byte-address width. Word index width is `AW = ADDR_WIDTH-2`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `src_base` in AW: source word index.
- `dst_base` in AW: destination word index.
- `len` in AW+1: word count, 0..2^AW.
- `busy` out 1: high in READ, WRITE and VERIFY.
- `done` out 1: one-cycle pulse in DONE.
- `err` out 1: verify mismatch flag; held until next accepted `start`.
- `err_off` out AW: word offset of the first mismatch.
- `Raddr1`, `Raddr2` out AW: read addresses, zero-extended to `ADDR_WIDTH` at the top level.
- `Rden1`, `Rden2` out 1: read enables.
- `Rdata1`, `Rdata2` in 32: asynchronous read data.
- `Waddr` out AW, `Wren` out 1, `Wdata` out 32: write port; memory writes at `clk` edge.

## Operation
- States: IDLE, READ, WRITE, VERIFY (only when verify is compiled in), DONE.
- IDLE, `start=1`:
  - Latch `src_base`, `dst_base`, `len`; clear offset counter `off`, `err`, `err_off`.
  - If `len==0`, go to DONE; otherwise go to READ.
- READ:
  - `Rden1=1`, `Raddr1=src+off`.
  - Capture `Rdata1` into `buf` at the edge; go to WRITE.
- WRITE:
  - `Wren=1`, `Waddr=dst+off`, `Wdata=buf`.
  - `off` increments.
  - If `off+1==len`, go to VERIFY (verify build) or DONE; else go to READ.
- VERIFY:
  - Walks `off` from 0, one word per cycle.
  - `Rden1=Rden2=1`, `Raddr1=src+off`, `Raddr2=dst+off`.
  - If `Rdata1!=Rdata2`: set `err=1`, `err_off=off`, go to DONE at once.
  - If the last word matches, go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Address arithmetic is modulo 2^AW; `src+off` and `dst+off` wrap silently.
- `len=2^AW` copies the entire memory.
- Copy order is strictly ascending.
  - Overlapping windows with `dst>src` smear the source; this is defined behaviour and is not corrected.
  - With `src==dst`, words are rewritten unchanged.
- `start` while not in IDLE is ignored; no queuing.
- All enables are decoded from the state register. Outside their states, enables and addresses are 0, and `Wdata` is 0 outside WRITE.

## Timing
- Reset, at the edge where `rst=1`: state=IDLE, `busy=0`, `done=0`, `err=0`, `err_off=0`, all enables 0, all addresses 0, `Wdata=0`, `off=0`, `buf=0`.
- `rst` mid-operation aborts at that edge.
  - Writes already completed stay in memory; no further write occurs.
  - `done` does not pulse.
- `start` accepted at edge T: READ occupies cycle T+1, WRITE T+2, and so on.
  - Copy takes 2·len cycles; `done` is high in cycle T+2·len+1.
  - With verify and no error, `done` is high in cycle T+3·len+1.
  - With a verify error at offset k, `done` is high in cycle T+2·len+k+2.
- `len=0`: `done` is high in cycle T+1; no memory access occurs.
- `busy` and `done` are never high together. `done` falls one cycle before a new `start` can be accepted.

## Configuration
- `MEM_DMA_VERIFY_EN` defined:
  - The VERIFY state, the compare logic and port-2 driving are built.
  - `err` and `err_off` behave as specified.
- Undefined:
  - No VERIFY state; WRITE of the last word goes directly to DONE.
  - `Rden2=0`, `Raddr2=0`, `err=0`, `err_off=0` constantly.

## Test plan
- Basic copy: preload mem[25..28]=11,22,33,44; start src=25, dst=50, len=4.
  - Expect mem[50..53]=11,22,33,44.
  - `done` in cycle T+9 (T+13 with verify), `err=0`.
- Zero length: start with len=0.
  - `done` in T+1; `Wren` never asserts; memory unchanged.
- Wrap-around (AW=8): start src=254, dst=10, len=4.
  - Reads 254, 255, 0, 1 in order; writes 10..13.
- Start while busy: pulse `start` with different bases during READ.
  - Ignored; original copy completes unaltered; exactly one `done`.
- Reset mid-copy: assert `rst` in the second WRITE cycle of a len=4 copy.
  - Only dst+0 and dst+1 are written; all outputs at reset values next cycle; no `done`.
- Verify mismatch (verify build): bench memory drops the write to dst+2, len=4.
  - `err=1`, `err_off=2`, `done` in T+12.
